// File: rtl/tilt_pkg.sv
// tilt_pkg: shared types and constants for the tilt angle scheduler.
//   state_t      scheduler FSM states
//   CH_*         channel indices (roll, pitch, yaw)
//   ANGLE_*      angle constants in rad*4096 units
//   next_chan()  channel search over an enable mask
package tilt_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_ISSUE,
      S_WAIT,
      S_FIX,
      S_DONE
   } state_t;

   localparam logic [1:0] CH_ROLL  = 2'd0;
   localparam logic [1:0] CH_PITCH = 2'd1;
   localparam logic [1:0] CH_YAW   = 2'd2;

   localparam int ANGLE_SCALE   = 4096;
   localparam int ANGLE_PI      = 12868;
   localparam int ANGLE_HALF_PI = 6434;

   // Returns {found, index}. With from_start set, the lowest enabled channel
   // is chosen; otherwise the lowest enabled channel above cur.
   function automatic logic [2:0] next_chan(input logic [2:0] mask,
                                            input logic [1:0] cur,
                                            input logic       from_start);
      logic [2:0] r;
      r = 3'b000;
      // Descending scan so the lowest qualifying index is written last.
      for (int i = 2; i >= 0; i--) begin
         if (mask[i] && (from_start || i > int'(cur)))
            r = {1'b1, 2'(i)};
      end
      return r;
   endfunction

endpackage

// File: rtl/tilt_operand_prep.sv
// tilt_operand_prep: combinational operand preparation for one CORDIC job.
//   chan     in  channel index (roll / pitch / yaw)
//   x, y, z  in  latched signed sample
//   num      out numerator for the CORDIC unit (after shift and fold)
//   den      out denominator for the CORDIC unit (after shift and fold)
//   fold     out denominator was negative, both operands were negated
//   num_neg  out sign of the numerator before folding
module tilt_operand_prep
   import tilt_pkg::*;
#(
   parameter int WIDTH    = 16,
   parameter int PRESHIFT = 2
) (
   input  logic [1:0]              chan,
   input  logic signed [WIDTH-1:0] x,
   input  logic signed [WIDTH-1:0] y,
   input  logic signed [WIDTH-1:0] z,
   output logic signed [WIDTH-1:0] num,
   output logic signed [WIDTH-1:0] den,
   output logic                    fold,
   output logic                    num_neg
);

   localparam logic signed [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};
   localparam logic signed [WIDTH-1:0] SMAX = ~SMIN;

   logic signed [WIDTH-1:0] raw_n, raw_d, sh_n, sh_d;

   // Negation that cannot overflow: the most negative code maps to the max.
   function automatic logic signed [WIDTH-1:0] sat_neg(input logic signed [WIDTH-1:0] v);
      return (v == SMIN) ? SMAX : -v;
   endfunction

   always_comb begin
      raw_n = y;
      raw_d = z;
      case (chan)
         CH_PITCH: begin raw_n = x; raw_d = z; end
         CH_YAW:   begin raw_n = y; raw_d = x; end
         default:  begin raw_n = y; raw_d = z; end
      endcase
      sh_n    = raw_n >>> PRESHIFT;
      sh_d    = raw_d >>> PRESHIFT;
      // Fold into the right half-plane so the CORDIC only sees den >= 0.
      fold    = sh_d[WIDTH-1];
      num_neg = raw_n[WIDTH-1];
      num     = fold ? sat_neg(sh_n) : sh_n;
      den     = fold ? sat_neg(sh_d) : sh_d;
   end

endmodule

// File: rtl/tilt_angle_scheduler.sv
// tilt_angle_scheduler: runs up to three atan2 jobs per accelerometer sample
// on one shared CORDIC vectoring unit and corrects each result to full circle.
//   i_clk, i_rst                 clock, synchronous active-high reset
//   i_x, i_y, i_z, i_sample_valid sample input with one-cycle strobe
//   i_chan_en                    channel mask (roll, pitch, yaw), taken at LOAD
//   o_cor_start, o_cor_y, o_cor_z CORDIC job request
//   i_cor_done, i_cor_angle      CORDIC result (done is sticky until next start)
//   o_roll, o_pitch, o_yaw       angles in rad*4096
//   o_valid, o_err               frame-complete strobe and timeout flag
//   o_busy, o_drop_count         frame in progress, saturating drop counter
module tilt_angle_scheduler
   import tilt_pkg::*;
#(
   parameter int WIDTH    = 16,
   parameter int PRESHIFT = 2,
   parameter int TIMEOUT  = 64
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic [WIDTH-1:0] i_x,
   input  logic [WIDTH-1:0] i_y,
   input  logic [WIDTH-1:0] i_z,
   input  logic             i_sample_valid,
   input  logic [2:0]       i_chan_en,
   output logic             o_cor_start,
   output logic [WIDTH-1:0] o_cor_y,
   output logic [WIDTH-1:0] o_cor_z,
   input  logic             i_cor_done,
   input  logic [WIDTH-1:0] i_cor_angle,
   output logic [WIDTH-1:0] o_roll,
   output logic [WIDTH-1:0] o_pitch,
   output logic [WIDTH-1:0] o_yaw,
   output logic             o_valid,
   output logic             o_err,
   output logic             o_busy,
   output logic [7:0]       o_drop_count
);

   localparam int CW = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0]    WAIT_LAST = CW'(TIMEOUT - 1);
   localparam logic [WIDTH-1:0] PI_W      = WIDTH'(ANGLE_PI);

   state_t state, nxt;

   logic signed [WIDTH-1:0] pend_x, pend_y, pend_z;
   logic signed [WIDTH-1:0] smp_x, smp_y, smp_z;
   logic                    pend_full;
   logic [2:0]              mask;
   logic [1:0]              chan;
   logic [CW-1:0]           wcnt;
   logic                    timed_out, err;
   logic signed [WIDTH-1:0] num, den;
   logic                    fold, num_neg;
   logic [2:0]              first_ch, after_ch;
   logic                    done_seen, expire;
   logic [WIDTH-1:0]        fixed;

   tilt_operand_prep #(.WIDTH(WIDTH), .PRESHIFT(PRESHIFT)) u_prep (
      .chan    (chan),
      .x       (smp_x),
      .y       (smp_y),
      .z       (smp_z),
      .num     (num),
      .den     (den),
      .fold    (fold),
      .num_neg (num_neg)
   );

   assign o_cor_y  = num;
   assign o_cor_z  = den;
   assign first_ch = next_chan(i_chan_en, 2'd0, 1'b1);
   assign after_ch = next_chan(mask, chan, 1'b0);

   // Done from the previous job may still be high in the first WAIT cycle.
   assign done_seen = (wcnt != '0) && i_cor_done;
   assign expire    = !done_seen && (wcnt == WAIT_LAST);

   always_comb begin
      if (timed_out)
         fixed = '0;
      else if (fold)
         fixed = num_neg ? (i_cor_angle - PI_W) : (i_cor_angle + PI_W);
      else
         fixed = i_cor_angle;
   end

   always_comb begin
      nxt = state;
      case (state)
         S_IDLE:  if (pend_full || i_sample_valid) nxt = S_LOAD;
         S_LOAD:  nxt = first_ch[2] ? S_ISSUE : S_DONE;
         S_ISSUE: nxt = S_WAIT;
         S_WAIT:  if (done_seen || expire) nxt = S_FIX;
         S_FIX:   nxt = after_ch[2] ? S_ISSUE : S_DONE;
         S_DONE:  nxt = S_IDLE;
         default: nxt = S_IDLE;
      endcase
   end

   assign o_cor_start = (state == S_ISSUE) && !i_rst;
   assign o_valid     = (state == S_DONE);
   assign o_err       = (state == S_DONE) && err;
   assign o_busy      = (state != S_IDLE);

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state        <= S_IDLE;
         pend_full    <= 1'b0;
         pend_x       <= '0;
         pend_y       <= '0;
         pend_z       <= '0;
         smp_x        <= '0;
         smp_y        <= '0;
         smp_z        <= '0;
         mask         <= '0;
         chan         <= '0;
         wcnt         <= '0;
         timed_out    <= 1'b0;
         err          <= 1'b0;
         o_roll       <= '0;
         o_pitch      <= '0;
         o_yaw        <= '0;
         o_drop_count <= '0;
      end else begin
         state <= nxt;

         // One-deep pending buffer. A sample landing in LOAD refills the slot
         // that LOAD is emptying, so it is not a drop.
         if (i_sample_valid) begin
            pend_x    <= i_x;
            pend_y    <= i_y;
            pend_z    <= i_z;
            pend_full <= 1'b1;
            if (pend_full && state != S_LOAD && o_drop_count != 8'hFF)
               o_drop_count <= o_drop_count + 8'd1;
         end else if (state == S_LOAD) begin
            pend_full <= 1'b0;
         end

         case (state)
            S_LOAD: begin
               smp_x <= pend_x;
               smp_y <= pend_y;
               smp_z <= pend_z;
               mask  <= i_chan_en;
               chan  <= first_ch[1:0];
               err   <= 1'b0;
            end
            S_ISSUE: begin
               wcnt      <= '0;
               timed_out <= 1'b0;
            end
            S_WAIT: begin
               wcnt <= wcnt + 1'b1;
               if (expire) begin
                  timed_out <= 1'b1;
                  err       <= 1'b1;
               end
            end
            S_FIX: begin
               case (chan)
                  CH_ROLL:  o_roll  <= fixed;
                  CH_PITCH: o_pitch <= fixed;
                  default:  o_yaw   <= fixed;
               endcase
               if (after_ch[2]) chan <= after_ch[1:0];
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_tilt_angle_scheduler.sv
// Bench for tilt_angle_scheduler with a behavioural CORDIC vectoring model.
module tb_tilt_angle_scheduler;

   localparam int W = 16;

   logic         i_clk = 1'b0;
   logic         i_rst;
   logic [W-1:0] i_x, i_y, i_z;
   logic         i_sample_valid;
   logic [2:0]   i_chan_en;
   logic         o_cor_start;
   logic [W-1:0] o_cor_y, o_cor_z;
   logic         i_cor_done;
   logic [W-1:0] i_cor_angle;
   logic [W-1:0] o_roll, o_pitch, o_yaw;
   logic         o_valid, o_err, o_busy;
   logic [7:0]   o_drop_count;

   int n_assert = 0;
   int n_fail   = 0;

   typedef struct {
      int   roll;
      int   pitch;
      int   yaw;
      logic err;
   } frame_t;

   frame_t sb[$];
   int     m_roll = 0, m_pitch = 0, m_yaw = 0;
   logic   no_done = 1'b0;

   always #5 i_clk = ~i_clk;

   tilt_angle_scheduler #(.WIDTH(W), .PRESHIFT(2), .TIMEOUT(64)) dut (
      .i_clk          (i_clk),
      .i_rst          (i_rst),
      .i_x            (i_x),
      .i_y            (i_y),
      .i_z            (i_z),
      .i_sample_valid (i_sample_valid),
      .i_chan_en      (i_chan_en),
      .o_cor_start    (o_cor_start),
      .o_cor_y        (o_cor_y),
      .o_cor_z        (o_cor_z),
      .i_cor_done     (i_cor_done),
      .i_cor_angle    (i_cor_angle),
      .o_roll         (o_roll),
      .o_pitch        (o_pitch),
      .o_yaw          (o_yaw),
      .o_valid        (o_valid),
      .o_err          (o_err),
      .o_busy         (o_busy),
      .o_drop_count   (o_drop_count)
   );

   function automatic int rnd(input real r);
      return (r >= 0.0) ? $rtoi(r + 0.5) : -$rtoi(-r + 0.5);
   endfunction

   function automatic int atan_q(input int n, input int d);
      return rnd($atan2($itor(n), $itor(d)) * 4096.0);
   endfunction

   // CORDIC model: start sampled, done rises 14 edges later so the DUT sees it
   // in its 15th WAIT cycle. The old done is dropped one edge late to
   // exercise the stale-done window.
   int   c_cnt;
   logic c_run;
   always @(posedge i_clk) begin
      if (i_rst) begin
         c_run       <= 1'b0;
         c_cnt       <= 0;
         i_cor_done  <= 1'b0;
         i_cor_angle <= '0;
      end else if (o_cor_start) begin
         c_run <= 1'b1;
         c_cnt <= 1;
      end else if (c_run) begin
         if (c_cnt == 1) i_cor_done <= 1'b0;
         if (c_cnt == 14) begin
            c_run <= 1'b0;
            if (!no_done) begin
               i_cor_done  <= 1'b1;
               i_cor_angle <= W'(atan_q($signed(o_cor_y), $signed(o_cor_z)));
            end
         end
         c_cnt <= c_cnt + 1;
      end
   end

   task automatic chk(input string tag, input int obs, input int exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic chk_near(input string tag, input logic [W-1:0] obs, input int exp);
      int   o;
      logic near;
      o    = $signed(obs);
      near = ((o - exp) <= 8) && ((o - exp) >= -8);
      n_assert++;
      assert (near === 1'b1) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d (+-8)", tag, o, exp);
      end
   endtask

   // Scoreboard: every o_valid pops one expected frame.
   always @(negedge i_clk) begin
      frame_t e;
      if (!i_rst && o_valid) begin
         if (sb.size() == 0) begin
            chk("unexpected_valid", sb.size(), 1);
         end else begin
            e = sb.pop_front();
            chk_near("roll", o_roll, e.roll);
            chk_near("pitch", o_pitch, e.pitch);
            chk_near("yaw", o_yaw, e.yaw);
            chk("err", int'(o_err), int'(e.err));
         end
      end
   end

   task automatic push(input int x, input int y, input int z,
                       input logic [2:0] mask, input logic tmo);
      frame_t f;
      if (mask[0]) m_roll  = tmo ? 0 : atan_q(y, z);
      if (mask[1]) m_pitch = tmo ? 0 : atan_q(x, z);
      if (mask[2]) m_yaw   = tmo ? 0 : atan_q(y, x);
      f.roll  = m_roll;
      f.pitch = m_pitch;
      f.yaw   = m_yaw;
      f.err   = tmo;
      sb.push_back(f);
   endtask

   task automatic step();
      @(posedge i_clk);
      #1;
   endtask

   task automatic send(input int x, input int y, input int z);
      i_x            = W'(x);
      i_y            = W'(y);
      i_z            = W'(z);
      i_sample_valid = 1'b1;
      step();
      i_sample_valid = 1'b0;
   endtask

   // Counts cycles from the LOAD cycle (n=1) up to the o_valid cycle.
   task automatic wait_valid(input int maxc, output int n);
      logic got;
      n   = 1;
      got = 1'b0;
      while (!got && n <= maxc) begin
         @(negedge i_clk);
         if (o_valid) got = 1'b1;
         else begin
            step();
            n++;
         end
      end
      if (!got) chk("valid_timeout", n, maxc);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n, x, y, z;
      i_rst = 1'b1;
      i_x = '0; i_y = '0; i_z = '0;
      i_sample_valid = 1'b0;
      i_chan_en = 3'b000;
      repeat (3) step();
      chk("rst_busy", int'(o_busy), 0);
      chk("rst_valid", int'(o_valid), 0);
      chk("rst_start", int'(o_cor_start), 0);
      chk("rst_roll", int'(o_roll), 0);
      chk("rst_drop", int'(o_drop_count), 0);
      i_rst = 1'b0;
      step();

      // Level sample, all channels, nominal frame length.
      i_chan_en = 3'b111;
      push(0, 0, 4096, 3'b111, 1'b0);
      send(0, 0, 4096);
      chk("busy_load", int'(o_busy), 1);
      wait_valid(200, n);
      chk("lat_full", n, 53);
      step();
      chk("idle_after", int'(o_busy), 0);

      // Fold path, roll only.
      i_chan_en = 3'b001;
      push(0, 4096, -4096, 3'b001, 1'b0);
      send(0, 4096, -4096);
      wait_valid(100, n);
      chk("lat_one", n, 19);
      step();
      push(0, -4096, -4096, 3'b001, 1'b0);
      send(0, -4096, -4096);
      wait_valid(100, n);
      step();

      // Mixed quadrants then random samples (multiples of 4: exact pre-shift).
      i_chan_en = 3'b111;
      push(-3000, 2000, -1500, 3'b111, 1'b0);
      send(-3000, 2000, -1500);
      wait_valid(200, n);
      step();
      for (int k = 0; k < 4; k++) begin
         x = (int'($urandom_range(0, 4000)) - 2000) * 4;
         y = (int'($urandom_range(0, 4000)) - 2000) * 4;
         z = (int'($urandom_range(0, 4000)) - 2000) * 4;
         push(x, y, z, 3'b111, 1'b0);
         send(x, y, z);
         wait_valid(200, n);
         step();
      end

      // Empty mask: immediate DONE, outputs held.
      i_chan_en = 3'b000;
      push(1000, 1000, 1000, 3'b000, 1'b0);
      send(1000, 1000, 1000);
      wait_valid(10, n);
      chk("lat_empty", n, 2);
      step();

      // Three samples during a frame: the middle one is overwritten.
      i_chan_en = 3'b111;
      push(1000, -2000, 3000, 3'b111, 1'b0);
      send(1000, -2000, 3000);
      repeat (4) step();
      send(4000, 4000, 4000);
      repeat (4) step();
      send(-2000, 1200, -800);
      push(-2000, 1200, -800, 3'b111, 1'b0);
      chk("drop_one", int'(o_drop_count), 1);
      wait_valid(200, n);
      step();
      wait_valid(200, n);
      step();
      chk("drop_hold", int'(o_drop_count), 1);

      // CORDIC never finishes: each enabled job aborts after 64 WAIT cycles.
      no_done   = 1'b1;
      i_chan_en = 3'b101;
      push(2000, 2000, 2000, 3'b101, 1'b1);
      send(2000, 2000, 2000);
      wait_valid(400, n);
      chk("lat_timeout", n, 134);
      step();
      no_done = 1'b0;

      // Reset during the ch1 WAIT abandons the frame.
      i_chan_en = 3'b111;
      push(800, -1600, 2400, 3'b111, 1'b0);
      send(800, -1600, 2400);
      repeat (24) step();
      chk("busy_mid", int'(o_busy), 1);
      i_rst = 1'b1;
      sb.delete();
      m_roll = 0; m_pitch = 0; m_yaw = 0;
      step();
      chk("mid_rst_roll", int'(o_roll), 0);
      chk("mid_rst_pitch", int'(o_pitch), 0);
      chk("mid_rst_yaw", int'(o_yaw), 0);
      chk("mid_rst_busy", int'(o_busy), 0);
      chk("mid_rst_drop", int'(o_drop_count), 0);
      i_rst = 1'b0;
      repeat (60) step();

      push(-1200, 3600, 2000, 3'b111, 1'b0);
      send(-1200, 3600, 2000);
      wait_valid(200, n);
      chk("lat_after_rst", n, 53);
      step();
      repeat (3) step();
      chk("sb_empty", sb.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
